// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the multi-phase sequencer.
package phase_seq_pkg;

  // Sequencer top-level states; encoding 3 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the optional wrap counter.
  localparam int LOOP_CNT_W = 16;

  // Effective dwell: a programmed 0 still occupies one cycle, so a phase is never skipped.
  function automatic logic [31:0] eff_dwell(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/phase_dwell_cnt.sv
// Loadable down-counter that times one phase.
// It stops at 1 and flags last there, so it never underflows or wraps.
module phase_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement only while above 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q > CNT_W'(1)))
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/phase_seq_fsm.sv
// Multi-phase sequencer: steps through NUM_PHASES phases, each held for a
// programmable dwell taken from a shadow copy of dwell_cfg latched at start.
// Supports abort, continuous loop mode and a done pulse. All outputs registered.
// Optional build macro PHASE_SEQ_LOOP_CNT_EN adds a saturating wrap counter output.
module phase_seq_fsm
  import phase_seq_pkg::*;
#(
  parameter  int NUM_PHASES = 4,
  parameter  int CNT_W      = 8,
  localparam int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        loop_en,
  input  logic [NUM_PHASES*CNT_W-1:0] dwell_cfg,
  output logic                        busy,
  output logic [PH_W-1:0]             phase,
  output logic                        phase_valid,
  output logic                        phase_first,
  output logic                        done
`ifdef PHASE_SEQ_LOOP_CNT_EN
  ,
  output logic [LOOP_CNT_W-1:0]       loop_cnt
`endif
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  state_e                             state_q, state_d;
  logic [PH_W-1:0]                    phase_q, phase_d;
  logic [NUM_PHASES-1:0][CNT_W-1:0]   shadow_q, shadow_d;
  logic                               busy_q, busy_d;
  logic                               first_q, first_d;
  logic                               done_q, done_d;

  logic                               cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0]                   cnt_load_val;
  logic [PH_W-1:0]                    phase_nxt;
  logic [NUM_PHASES-1:0][CNT_W-1:0]   dwell_in;

`ifdef PHASE_SEQ_LOOP_CNT_EN
  logic [LOOP_CNT_W-1:0]              loop_cnt_q, loop_cnt_d;
`endif

  assign dwell_in  = dwell_cfg;
  assign phase_nxt = phase_q + PH_W'(1);

  phase_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .last     (cnt_last)
  );

  // Next-state, phase advance, counter control and registered-output values.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    shadow_d     = shadow_q;
    first_d      = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
`ifdef PHASE_SEQ_LOOP_CNT_EN
    loop_cnt_d   = loop_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // abort cancels a same-cycle start
        if (start && !abort) begin
          shadow_d     = dwell_in;
          state_d      = RUN;
          phase_d      = '0;
          first_d      = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(eff_dwell(32'(dwell_in[0])));
`ifdef PHASE_SEQ_LOOP_CNT_EN
          loop_cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (cnt_last) begin
          if (phase_q == LAST_PH) begin
            if (loop_en) begin
              phase_d      = '0;
              first_d      = 1'b1;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(eff_dwell(32'(shadow_q[0])));
`ifdef PHASE_SEQ_LOOP_CNT_EN
              if (loop_cnt_q != '1) loop_cnt_d = loop_cnt_q + LOOP_CNT_W'(1);
`endif
            end else begin
              state_d = DONE;
              phase_d = '0;
              done_d  = 1'b1;
            end
          end else begin
            phase_d      = phase_nxt;
            first_d      = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(eff_dwell(32'(shadow_q[phase_nxt])));
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State, phase, shadow and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      first_q  <= first_d;
      done_q   <= done_d;
    end
  end

`ifdef PHASE_SEQ_LOOP_CNT_EN
  // Wrap counter; holds after abort/done until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) loop_cnt_q <= '0;
    else        loop_cnt_q <= loop_cnt_d;
  end
  assign loop_cnt = loop_cnt_q;
`endif

  assign busy        = busy_q;
  assign phase_valid = busy_q;
  assign phase       = phase_q;
  assign phase_first = first_q;
  assign done        = done_q;

endmodule

// File: tb/tb_phase_seq_fsm.sv
// Self-checking bench for phase_seq_fsm (NUM_PHASES=4, CNT_W=8).
// Each vector carries the inputs applied for one cycle and the outputs
// expected right after the following rising edge.
module tb_phase_seq_fsm;

  typedef struct {
    logic        st, ab, lp, rn;
    logic [31:0] dw;
    logic        bz;
    logic [1:0]  ph;
    logic        pf, dn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, loop_en = 1'b0;
  logic [31:0] dwell_cfg = '0;
  logic        busy, phase_valid, phase_first, done;
  logic [1:0]  phase;
`ifdef PHASE_SEQ_LOOP_CNT_EN
  logic [15:0] loop_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int vec_no = 0;
  vec_t sb_q[$];

  phase_seq_fsm #(.NUM_PHASES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .loop_en     (loop_en),
    .dwell_cfg   (dwell_cfg),
    .busy        (busy),
    .phase       (phase),
    .phase_valid (phase_valid),
    .phase_first (phase_first),
    .done        (done)
`ifdef PHASE_SEQ_LOOP_CNT_EN
    ,
    .loop_cnt    (loop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic ab, logic lp, logic rn, logic [31:0] dw,
                              logic bz, logic [1:0] ph, logic pf, logic dn);
    vec_t v;
    v.st = st; v.ab = ab; v.lp = lp; v.rn = rn; v.dw = dw;
    v.bz = bz; v.ph = ph; v.pf = pf; v.dn = dn;
    return v;
  endfunction

  function automatic int eff(logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  // Drive one vector, push its expectation, clock, then pop and compare.
  task automatic step(input vec_t v);
    vec_t e;
    start = v.st; abort = v.ab; loop_en = v.lp; rst_n = v.rn; dwell_cfg = v.dw;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_chk++;
    if (busy === e.bz && phase_valid === e.bz && phase === e.ph &&
        phase_first === e.pf && done === e.dn)
      n_pass++;
    else
      $display("FAIL vec%0d: got busy=%b pv=%b phase=%0d first=%b done=%b, want busy=%b pv=%b phase=%0d first=%b done=%b",
               vec_no, busy, phase_valid, phase, phase_first, done, e.bz, e.bz, e.ph, e.pf, e.dn);
    vec_no++;
  endtask

  // Expected timeline of a one-shot run built from the dwell list.
  task automatic run_oneshot(input logic [31:0] dw);
    vec_t tl[$];
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < eff(dw[k*8 +: 8]); j++)
        tl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, dw, 1'b1, 2'(k), (j == 0), 1'b0));
    tl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, dw, 1'b0, 2'd0, 1'b0, 1'b1));
    tl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, dw, 1'b0, 2'd0, 1'b0, 1'b0));
    tl[0].st = 1'b1;
    foreach (tl[i]) step(tl[i]);
  endtask

  vec_t tbl[16];

  initial begin
    // reset, start+abort in IDLE, then dwell {1,2,3,4} one-shot with
    // dwell_cfg changed to FF mid-run, start in RUN and in DONE ignored
    tbl[0]  = mk(0,0,0,0, 32'h04030201, 0,0,0,0);
    tbl[1]  = mk(1,1,0,1, 32'h04030201, 0,0,0,0);
    tbl[2]  = mk(1,0,0,1, 32'h04030201, 1,0,1,0);
    tbl[3]  = mk(0,0,0,1, 32'h04030201, 1,1,1,0);
    tbl[4]  = mk(0,0,0,1, 32'h04030201, 1,1,0,0);
    tbl[5]  = mk(0,0,0,1, 32'hFFFFFFFF, 1,2,1,0);
    tbl[6]  = mk(1,0,0,1, 32'hFFFFFFFF, 1,2,0,0);
    tbl[7]  = mk(0,0,0,1, 32'hFFFFFFFF, 1,2,0,0);
    tbl[8]  = mk(0,0,0,1, 32'hFFFFFFFF, 1,3,1,0);
    tbl[9]  = mk(0,0,0,1, 32'hFFFFFFFF, 1,3,0,0);
    tbl[10] = mk(0,0,0,1, 32'hFFFFFFFF, 1,3,0,0);
    tbl[11] = mk(0,0,0,1, 32'hFFFFFFFF, 1,3,0,0);
    tbl[12] = mk(1,0,0,1, 32'hFFFFFFFF, 0,0,0,1);
    tbl[13] = mk(1,0,0,1, 32'hFFFFFFFF, 0,0,0,0);
    tbl[14] = mk(0,0,0,1, 32'hFFFFFFFF, 0,0,0,0);
    tbl[15] = mk(0,1,1,1, 32'hFFFFFFFF, 0,0,0,0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) step(tbl[i]);

    // zero dwell = one cycle per phase
    run_oneshot(32'h00000000);
    run_oneshot(32'h01020304);

    // loop mode, dwell 1; loop_en dropped during phase 2 of the third pass
    for (int i = 0; i < 12; i++)
      step(mk((i == 0), 1'b0, (i < 10), 1'b1, 32'h01010101, 1'b1, 2'(i % 4), 1'b1, 1'b0));
    step(mk(0,0,0,1, 32'h01010101, 0,0,0,1));
    step(mk(0,0,0,1, 32'h01010101, 0,0,0,0));
`ifdef PHASE_SEQ_LOOP_CNT_EN
    n_chk++;
    if (loop_cnt === 16'd2) n_pass++;
    else $display("FAIL loop_cnt: got %0d want 2", loop_cnt);
`endif

    // abort on cycle 5, restart on cycle 7, reset mid-sequence
    step(mk(1,0,0,1, 32'h04030201, 1,0,1,0));
    step(mk(0,0,0,1, 32'h04030201, 1,1,1,0));
    step(mk(0,0,0,1, 32'h04030201, 1,1,0,0));
    step(mk(0,0,0,1, 32'h04030201, 1,2,1,0));
    step(mk(0,0,0,1, 32'h04030201, 1,2,0,0));
    step(mk(0,1,0,1, 32'h04030201, 0,0,0,0));
    step(mk(0,0,0,1, 32'h04030201, 0,0,0,0));
    step(mk(1,0,0,1, 32'h04030201, 1,0,1,0));
    step(mk(0,0,0,1, 32'h04030201, 1,1,1,0));
    step(mk(0,0,0,1, 32'h04030201, 1,1,0,0));
    step(mk(0,0,0,1, 32'h04030201, 1,2,1,0));
    step(mk(0,0,0,1, 32'h04030201, 1,2,0,0));
    step(mk(0,0,0,1, 32'h04030201, 1,2,0,0));
    step(mk(0,0,0,0, 32'h04030201, 0,0,0,0));
    for (int i = 0; i < 6; i++) step(mk(0,0,0,1, 32'h04030201, 0,0,0,0));

    // 255-cycle phases, no counter wrap at 8'hFF
    run_oneshot(32'hFFFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/phase_seq_fsm.md
Name: phase_seq_fsm

Overview:
- Parametrised multi-phase sequencer; successor to the fixed 4-state start-triggered sequencer.
- Steps through NUM_PHASES phases. Each phase holds for a programmable dwell time.
- Adds abort, continuous-loop mode and a done pulse.
- Drives phase-indexed control in datapath blocks, e.g. mux selects and enables per phase.

Parameters:
- NUM_PHASES, 4: number of phases, >=2.
- CNT_W, 8: width of each per-phase dwell count.
- PH_W, $clog2(NUM_PHASES): phase index width. Localparam, derived, not overridable.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  terminate sequence immediately; highest priority after reset.
- loop_en  in  1  when 1, wrap from last phase to phase 0 instead of finishing.
- dwell_cfg  in  NUM_PHASES*CNT_W  dwell per phase; slice k = bits [k*CNT_W +: CNT_W].
- busy  out  1  high while in RUN.
- phase  out  PH_W  current phase index; 0 when not in RUN.
- phase_valid  out  1  equals busy; qualifies phase.
- phase_first  out  1  one-cycle pulse on the first cycle of every phase.
- done  out  1  one-cycle pulse; sequence completed normally.

Behaviour:
- Reset values: state=IDLE, phase=0, busy=0, phase_valid=0, phase_first=0, done=0, dwell counter=0, config shadow=0.
- States: IDLE, RUN, DONE, held in an enum from the package.
- IDLE, start=1, abort=0: latch dwell_cfg into a shadow register. Enter RUN with phase=0 and load the counter with eff(dwell[0]).
- Latency: start high at edge T gives phase_valid=1, phase=0, phase_first=1 after edge T+1.
- eff(d) = (d==0) ? 1 : d. A dwell of 0 is treated as 1 cycle, never as skip or wrap.
- RUN: phase k holds exactly eff(dwell[k]) cycles. On the last cycle of phase k with k<NUM_PHASES-1: phase <= k+1, reload counter, phase_first pulses next cycle.
- Last cycle of phase NUM_PHASES-1, loop_en=1: phase <= 0 and reload from the shadow. done is not asserted.
- Last cycle of phase NUM_PHASES-1, loop_en=0: go to DONE.
- loop_en is sampled only on that final cycle.
- DONE: lasts one cycle with done=1, busy=0, phase=0. Returns to IDLE unconditionally. start during DONE is ignored.
- abort=1 in RUN: next state IDLE, busy=0, phase=0, no done pulse. abort in IDLE or DONE has no effect beyond cancelling a same-cycle start.
- start and abort both high in IDLE: abort wins; remain IDLE.
- start while in RUN is ignored. dwell_cfg changes while in RUN are ignored (shadow copy is used). A new dwell_cfg takes effect at the next start.
- rst_n low at any time, including mid-sequence: all state returns to reset values on that edge. No done pulse.
- Counter arithmetic: down-counter, CNT_W bits, decrements to 1, then the phase advance occurs. The counter never underflows or wraps.
- Illegal or unreached state encoding: default branch returns to IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PHASE_SEQ_LOOP_CNT_EN.
- When defined: adds output loop_cnt [15:0]. Cleared on reset and on each accepted start. Increments on every wrap in loop mode. Saturates at 16'hFFFF. Holds its value after abort or done until the next start.
- When undefined: port and logic are absent; behaviour otherwise identical.

Decomposition:
- Package phase_seq_pkg:
  - state enum typedef (IDLE=0, RUN=1, DONE=2), 2 bits.
  - a function returning eff(d).
  - loop_cnt width constant (16).
- One sub-module: phase_dwell_cnt. CNT_W-bit loadable down-counter with load, load_val and en inputs and a last output (count==1). Instantiated once.
- FSM, phase index and shadow register stay in the top module.

Test Plan:
- NUM_PHASES=4, dwell={1,2,3,4}, start pulsed at cycle 0, loop_en=0:
  - phase 0 at cycle 1; phase 1 at cycles 2-3; phase 2 at 4-6; phase 3 at 7-10.
  - done=1 at cycle 11 only; busy=0 from cycle 11.
  - phase_first at cycles 1, 2, 4, 7.
- dwell={0,0,0,0}: phases 0..3 on cycles 1..4, one cycle each; done at cycle 5.
- loop_en=1, dwell={1,1,1,1}: phase pattern 0,1,2,3,0,1... with no done. Drop loop_en during phase 2 of the third pass: done fires after phase 3. With the macro enabled, loop_cnt=2.
- Abort on cycle 5 of the first scenario: busy=0 and phase=0 on cycle 6; no done ever. A start on cycle 7 restarts at phase 0 on cycle 8.
- rst_n low on cycle 6 mid-sequence: all outputs zero on cycle 7. start and abort high together in IDLE: remains IDLE.
- Change dwell_cfg to all 8'hFF during RUN: current sequence timing unchanged. The next start uses 255 cycles per phase; no counter wrap at 8'hFF.
